// File: rtl/ex_stage.sv
// Execute stage: ALU, beq/bne resolution, destination select and EX/MEM register.
// Shifts iterate one bit per cycle unless EX_FAST_SHIFT_EN selects a barrel shifter.
module ex_stage #(
    parameter int DW  = 32,
    parameter int PCW = 7,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [PCW-1:0] pc_i,
    input  logic [DW-1:0]  rs_val_i,
    input  logic [DW-1:0]  rt_val_i,
    input  logic [DW-1:0]  offset_i,
    input  logic [4:0]     rt_i,
    input  logic [4:0]     rd_i,
    input  logic [SHW-1:0] shamt_i,
    input  logic [1:0]     wb_i,
    input  logic [2:0]     mem_i,
    input  logic [2:0]     aluop_i,
    input  logic           alusrc_i,
    input  logic           regdst_i,
    input  logic           bne_i,
    output logic           stall_o,
    output logic [1:0]     wb_o,
    output logic [2:0]     mem_o,
    output logic [DW-1:0]  alu_res_o,
    output logic [DW-1:0]  store_data_o,
    output logic [4:0]     dst_o,
    output logic [PCW-1:0] br_target_o,
    output logic           br_taken_o
);
    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
                           OP_SLT = 3'b100, OP_SLL = 3'b101, OP_SRL = 3'b110, OP_NOR = 3'b111;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;
    state_e state_q, state_d;

    logic [1:0]     wb_q, wb_d, lwb_q, lwb_d;
    logic [2:0]     mem_q, mem_d, lmem_q, lmem_d;
    logic [DW-1:0]  res_q, res_d, sd_q, sd_d, lsd_q, lsd_d, acc_q, acc_d;
    logic [4:0]     dst_q, dst_d, ldst_q, ldst_d;
    logic [PCW-1:0] tgt_q, tgt_d, ltgt_q, ltgt_d;
    logic           taken_q, taken_d, lright_q, lright_d;
    logic [SHW-1:0] cnt_q, cnt_d;

    logic           is_shift, start_iter;
    logic [DW-1:0]  op_b, alu_res, acc_step;
    logic [4:0]     dst_sel;
    logic [PCW-1:0] tgt_sum;

    assign is_shift = (aluop_i == OP_SLL) || (aluop_i == OP_SRL);
    assign dst_sel  = regdst_i ? rd_i : rt_i;
    assign tgt_sum  = pc_i + offset_i[PCW-1:0];
    assign acc_step = lright_q ? (acc_q >> 1) : (acc_q << 1);
`ifdef EX_FAST_SHIFT_EN
    assign start_iter = 1'b0;
`else
    assign start_iter = (state_q == IDLE) && is_shift && (shamt_i >= SHW'(2));
`endif

    always_comb begin
        op_b    = alusrc_i ? offset_i : rt_val_i;
        alu_res = '0;
        case (aluop_i)
            OP_ADD: alu_res = rs_val_i + op_b;
            OP_SUB: alu_res = rs_val_i - op_b;
            OP_AND: alu_res = rs_val_i & op_b;
            OP_OR:  alu_res = rs_val_i | op_b;
            OP_SLT: alu_res = {{(DW-1){1'b0}}, ($signed(rs_val_i) < $signed(op_b))};
`ifdef EX_FAST_SHIFT_EN
            OP_SLL: alu_res = rt_val_i << shamt_i;
            OP_SRL: alu_res = rt_val_i >> shamt_i;
`else
            // Only shamt 0/1 reaches here; longer shifts go through the iterative path.
            OP_SLL: alu_res = shamt_i[0] ? (rt_val_i << 1) : rt_val_i;
            OP_SRL: alu_res = shamt_i[0] ? (rt_val_i >> 1) : rt_val_i;
`endif
            OP_NOR: alu_res = ~(rs_val_i | op_b);
            default: alu_res = '0;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_iter) state_d = SHIFT;
            SHIFT: if (cnt_q == SHW'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
`ifdef EX_FAST_SHIFT_EN
        stall_o = 1'b0;
`else
        stall_o = (state_q == SHIFT);
`endif
    end

    always_comb begin
        acc_d = acc_q;  cnt_d = cnt_q;
        lwb_d = lwb_q;  lmem_d = lmem_q; lsd_d = lsd_q;
        ldst_d = ldst_q; ltgt_d = ltgt_q; lright_d = lright_q;
        wb_d = '0; mem_d = '0; res_d = '0; sd_d = '0; dst_d = '0; tgt_d = '0; taken_d = 1'b0;
        if (state_q == IDLE) begin
            if (start_iter) begin
                lwb_d    = wb_i;
                lmem_d   = mem_i;
                lsd_d    = rt_val_i;
                ldst_d   = dst_sel;
                ltgt_d   = tgt_sum;
                lright_d = (aluop_i == OP_SRL);
                acc_d    = (aluop_i == OP_SRL) ? (rt_val_i >> 1) : (rt_val_i << 1);
                cnt_d    = shamt_i - SHW'(1);
            end else begin
                wb_d    = wb_i;
                mem_d   = mem_i;
                res_d   = alu_res;
                sd_d    = rt_val_i;
                dst_d   = dst_sel;
                tgt_d   = tgt_sum;
                taken_d = !is_shift && mem_i[2] && ((rs_val_i == rt_val_i) ^ bne_i);
            end
        end else begin
            acc_d = acc_step;
            cnt_d = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
                wb_d  = lwb_q;
                mem_d = lmem_q;
                res_d = acc_step;
                sd_d  = lsd_q;
                dst_d = ldst_q;
                tgt_d = ltgt_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q <= '0; mem_q <= '0; res_q <= '0; sd_q <= '0; dst_q <= '0; tgt_q <= '0;
            taken_q <= 1'b0; acc_q <= '0; cnt_q <= '0;
            lwb_q <= '0; lmem_q <= '0; lsd_q <= '0; ldst_q <= '0; ltgt_q <= '0; lright_q <= 1'b0;
        end else begin
            wb_q <= wb_d; mem_q <= mem_d; res_q <= res_d; sd_q <= sd_d; dst_q <= dst_d;
            tgt_q <= tgt_d; taken_q <= taken_d; acc_q <= acc_d; cnt_q <= cnt_d;
            lwb_q <= lwb_d; lmem_q <= lmem_d; lsd_q <= lsd_d; ldst_q <= ldst_d;
            ltgt_q <= ltgt_d; lright_q <= lright_d;
        end
    end

    assign wb_o         = wb_q;
    assign mem_o        = mem_q;
    assign alu_res_o    = res_q;
    assign store_data_o = sd_q;
    assign dst_o        = dst_q;
    assign br_target_o  = tgt_q;
    assign br_taken_o   = taken_q;
endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed cases plus random instructions against a behavioural model.
module tb_ex_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic [6:0]  pc_i;
    logic [31:0] rs_val_i, rt_val_i, offset_i;
    logic [4:0]  rt_i, rd_i, shamt_i;
    logic [1:0]  wb_i;
    logic [2:0]  mem_i, aluop_i;
    logic        alusrc_i, regdst_i, bne_i;
    logic        stall_o, br_taken_o;
    logic [1:0]  wb_o;
    logic [2:0]  mem_o;
    logic [31:0] alu_res_o, store_data_o;
    logic [4:0]  dst_o;
    logic [6:0]  br_target_o;

    int n_pass = 0, n_checks = 0;

    typedef struct {
        logic [6:0]  pc;
        logic [31:0] rs, rt, off;
        logic [4:0]  rt_a, rd_a, shamt;
        logic [1:0]  wb;
        logic [2:0]  mem, op;
        logic        alusrc, regdst, bne;
    } instr_t;

    ex_stage dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .rs_val_i(rs_val_i), .rt_val_i(rt_val_i),
        .offset_i(offset_i), .rt_i(rt_i), .rd_i(rd_i), .shamt_i(shamt_i), .wb_i(wb_i),
        .mem_i(mem_i), .aluop_i(aluop_i), .alusrc_i(alusrc_i), .regdst_i(regdst_i),
        .bne_i(bne_i), .stall_o(stall_o), .wb_o(wb_o), .mem_o(mem_o), .alu_res_o(alu_res_o),
        .store_data_o(store_data_o), .dst_o(dst_o), .br_target_o(br_target_o),
        .br_taken_o(br_taken_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input instr_t in);
        pc_i = in.pc; rs_val_i = in.rs; rt_val_i = in.rt; offset_i = in.off;
        rt_i = in.rt_a; rd_i = in.rd_a; shamt_i = in.shamt; wb_i = in.wb; mem_i = in.mem;
        aluop_i = in.op; alusrc_i = in.alusrc; regdst_i = in.regdst; bne_i = in.bne;
    endtask

    function automatic instr_t rand_instr();
        instr_t r;
        r.pc = 7'($urandom); r.rs = $urandom; r.rt = $urandom; r.off = $urandom;
        if ($urandom_range(0, 3) == 0) r.rt = r.rs;
        if ($urandom_range(0, 3) == 0) r.off = $urandom_range(0, 20) - 10;
        r.rt_a = 5'($urandom); r.rd_a = 5'($urandom);
        r.shamt = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
        r.wb = 2'($urandom); r.mem = 3'($urandom); r.op = 3'($urandom);
        r.alusrc = 1'($urandom); r.regdst = 1'($urandom); r.bne = 1'($urandom);
        return r;
    endfunction

    function automatic instr_t nop();
        instr_t r;
        r.pc = '0; r.rs = '0; r.rt = '0; r.off = '0; r.rt_a = '0; r.rd_a = '0; r.shamt = '0;
        r.wb = '0; r.mem = '0; r.op = '0; r.alusrc = 1'b0; r.regdst = 1'b0; r.bne = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] model_res(input instr_t in);
        logic [31:0] b;
        b = in.alusrc ? in.off : in.rt;
        case (in.op)
            3'd0: return in.rs + b;
            3'd1: return in.rs - b;
            3'd2: return in.rs & b;
            3'd3: return in.rs | b;
            3'd4: return ($signed(in.rs) < $signed(b)) ? 32'd1 : 32'd0;
            3'd5: return in.rt << in.shamt;
            3'd6: return in.rt >> in.shamt;
            default: return ~(in.rs | b);
        endcase
    endfunction

    // Issue one instruction at #1 after an edge; returns with time at #1 after its result edge.
    task automatic issue(input string tag, input instr_t in);
        bit is_sh;
        int lat;
        logic [6:0] tgt;
        is_sh = (in.op == 3'd5) || (in.op == 3'd6);
`ifdef EX_FAST_SHIFT_EN
        lat = 1;
`else
        lat = (is_sh && in.shamt >= 2) ? int'(in.shamt) : 1;
`endif
        tgt = in.pc + in.off[6:0];
        drive(in);
        check({tag, ".stall_idle"}, 64'(stall_o), 64'd0);
        for (int k = 1; k < lat; k++) begin
            @(posedge clk); #1;
            check({tag, ".stall"}, 64'(stall_o), 64'd1);
            check({tag, ".bub_wb"}, 64'(wb_o), 64'd0);
            check({tag, ".bub_mem"}, 64'(mem_o), 64'd0);
            check({tag, ".bub_br"}, 64'(br_taken_o), 64'd0);
            drive(rand_instr());
        end
        @(posedge clk); #1;
        check({tag, ".alu_res"}, 64'(alu_res_o), 64'(model_res(in)));
        check({tag, ".dst"}, 64'(dst_o), 64'(in.regdst ? in.rd_a : in.rt_a));
        check({tag, ".wb"}, 64'(wb_o), 64'(in.wb));
        check({tag, ".mem"}, 64'(mem_o), 64'(in.mem));
        check({tag, ".store"}, 64'(store_data_o), 64'(in.rt));
        check({tag, ".tgt"}, 64'(br_target_o), 64'(tgt));
        check({tag, ".taken"}, 64'(br_taken_o),
              64'(!is_sh && in.mem[2] && ((in.rs == in.rt) != in.bne)));
        check({tag, ".stall_done"}, 64'(stall_o), 64'd0);
    endtask

    initial begin
        instr_t t;
        drive(nop());
        #1;
        check("rst.alu", 64'(alu_res_o), 64'd0);
        check("rst.wb", 64'(wb_o), 64'd0);
        check("rst.dst", 64'(dst_o), 64'd0);
        check("rst.stall", 64'(stall_o), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        t = nop(); t.op = 3'd0; t.rs = 5; t.off = 3; t.alusrc = 1; t.regdst = 1; t.rd_a = 9;
        t.wb = 2'b10;
        issue("add", t);
        t = nop(); t.op = 3'd1; t.rs = 2; t.rt = 7; issue("sub", t);
        t = nop(); t.op = 3'd4; t.rs = 32'hFFFF_FFFF; t.rt = 1; issue("slt", t);
        t = nop(); t.op = 3'd7; issue("nor", t);
        t = nop(); t.op = 3'd1; t.rs = 4; t.rt = 4; t.mem = 3'b100; t.pc = 7'h7E; t.off = 3;
        issue("beq", t);
        t.bne = 1; issue("bne", t);
        t = nop(); t.op = 3'd5; t.rt = 1; t.shamt = 4; t.regdst = 1; t.rd_a = 17; t.wb = 2'b11;
        issue("sll4", t);
        t = nop(); t.op = 3'd6; t.rt = 32'h8000_0000; t.shamt = 31; t.rt_a = 3; t.mem = 3'b110;
        issue("srl31", t);
        t.shamt = 0; issue("srl0", t);
        t.shamt = 1; issue("srl1", t);
        t = nop(); t.op = 3'd5; t.rt = 32'h0000_0003; t.shamt = 2; t.mem = 3'b101; t.rs = 3;
        issue("sll2_nobr", t);

        // Reset in the middle of an sll must abort it without ever emitting its result.
        t = nop(); t.op = 3'd5; t.rt = 1; t.shamt = 4; t.wb = 2'b11; t.mem = 3'b010;
        t.regdst = 1; t.rd_a = 21;
        drive(t);
        @(posedge clk); #1;
        drive(nop());
        @(posedge clk); #1;
        check("rstmid.stall_pre", 64'(stall_o), 64'd1);
        #2 rst = 1'b1; #1;
        check("rstmid.stall", 64'(stall_o), 64'd0);
        check("rstmid.alu", 64'(alu_res_o), 64'd0);
        check("rstmid.wb", 64'(wb_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("rstmid.no_res", 64'({wb_o, mem_o, dst_o, alu_res_o}), 64'd0);
            check("rstmid.idle", 64'(stall_o), 64'd0);
        end

        for (int i = 0; i < 300; i++) issue("rand", rand_instr());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
